counter: RTL and testbench

Parameterised synchronous up-counter with enable and a configurable range and step. `out` runs from COUNT_FROM towards COUNT_TO in increments of STEP, then wraps back to COUNT_FROM. It is a general-purpose leaf block for address and sequence generation and for timebases. Two selectable implementations give identical cycle behaviour.

---
 rtl/counter_pkg.sv | 33 +++
 rtl/counter_adder.sv | 33 +++
 rtl/counter.sv | 129 ++++++++++++
 tb/tb_counter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg -- shared definitions for the counter block.
//   ARCH_BEHAVIORAL / ARCH_STRUCTURAL : legal values of counter's ARCHITECTURE
//   counter_params_ok()               : constant function checking that the
//                                       range/step parameters fit DATA_WIDTH
// No ports (package).
package counter_pkg;

   localparam string ARCH_BEHAVIORAL = "BEHAVIORAL";
   localparam string ARCH_STRUCTURAL = "STRUCTURAL";

   localparam int unsigned MAX_DATA_WIDTH = 32'd32;

   // True when width is 1..32, FROM <= TO, both fit the width, and STEP is
   // 1..2**width-1. 64-bit arithmetic keeps the 2**32 limit representable.
   function automatic bit counter_params_ok(
      input int unsigned     data_width,
      input longint unsigned from_v,
      input longint unsigned to_v,
      input longint unsigned step_v
   );
      longint unsigned lim_v;
      bit              ok_v;
      if ((data_width < 32'd1) || (data_width > MAX_DATA_WIDTH)) begin
         ok_v = 1'b0;
      end else begin
         lim_v = 64'd1 << data_width;
         ok_v  = (from_v < lim_v) && (to_v < lim_v) && (from_v <= to_v) &&
                 (step_v >= 64'd1) && (step_v < lim_v);
      end
      return ok_v;
   endfunction

endpackage

// File: rtl/counter_adder.sv
// counter_adder -- plain ripple-carry adder with carry-in and carry-out.
// Ports:
//   a, b  [WIDTH-1:0]  operands
//   cin               carry-in
//   sum   [WIDTH-1:0]  a + b + cin (low WIDTH bits)
//   cout              carry-out of the top bit
module counter_adder
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] carry_s;

   // Bit-serial carry chain, one full adder per bit.
   always_comb begin
      carry_s    = '0;
      sum        = '0;
      carry_s[0] = cin;
      for (int i = 0; i < int'(WIDTH); i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry_s[i];
         carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
      end
      cout = carry_s[WIDTH];
   end

endmodule

// File: rtl/counter.sv
// counter -- parameterised synchronous up-counter with enable, range and step.
// out runs COUNT_FROM, COUNT_FROM+STEP, ... while a full step still fits below
// COUNT_TO, then reloads COUNT_FROM.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high (loads COUNT_FROM, beats en)
//   en    count enable
//   out   [DATA_WIDTH-1:0] current count, straight from the state register
//   wrap  (only with COUNTER_WRAP_FLAG_EN defined) high for the one cycle in
//         which out has just been reloaded by the wrap rule
// ARCHITECTURE selects an inferred ("BEHAVIORAL") or explicit-adder
// ("STRUCTURAL") datapath; both produce the same sequence.
module counter
   import counter_pkg::*;
#(
   parameter string       ARCHITECTURE = ARCH_BEHAVIORAL,
   parameter int unsigned DATA_WIDTH   = 32'd8,
   parameter int unsigned COUNT_FROM   = 32'd0,
   parameter int unsigned COUNT_TO     = 32'd255,
   parameter int unsigned STEP         = 32'd1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   output logic [DATA_WIDTH-1:0] out
`ifdef COUNTER_WRAP_FLAG_EN
   ,
   output logic                  wrap
`endif
);

   localparam logic [DATA_WIDTH-1:0] FROM_C = DATA_WIDTH'(COUNT_FROM);
   localparam logic [DATA_WIDTH-1:0] TO_C   = DATA_WIDTH'(COUNT_TO);
   localparam logic [DATA_WIDTH-1:0] STEP_C = DATA_WIDTH'(STEP);

   if (!counter_params_ok(DATA_WIDTH, longint'(COUNT_FROM), longint'(COUNT_TO),
                          longint'(STEP))) begin : g_param_err
      $error("counter: illegal DATA_WIDTH/COUNT_FROM/COUNT_TO/STEP combination");
   end

   logic [DATA_WIDTH-1:0] count_r;
   logic [DATA_WIDTH-1:0] next_s;
   logic                  wrap_s;

   if (ARCHITECTURE == ARCH_BEHAVIORAL) begin : g_beh
      logic [DATA_WIDTH:0] sum_s;
      logic [DATA_WIDTH:0] rem_s;

      // Next count: wrap when the distance left to COUNT_TO is below STEP.
      always_comb begin
         sum_s  = {1'b0, count_r} + {1'b0, STEP_C};
         rem_s  = {1'b0, TO_C} - {1'b0, count_r};
         // rem_s[MSB] set means count_r > COUNT_TO (corrupted state): reload.
         // sum_s[MSB] can only be set in that same situation; kept as a guard.
         wrap_s = rem_s[DATA_WIDTH] | (rem_s[DATA_WIDTH-1:0] < STEP_C) |
                  sum_s[DATA_WIDTH];
         if (wrap_s) begin
            next_s = FROM_C;
         end else begin
            next_s = sum_s[DATA_WIDTH-1:0];
         end
      end
   end else if (ARCHITECTURE == ARCH_STRUCTURAL) begin : g_str
      logic [DATA_WIDTH-1:0] sum_lo_s;
      logic                  sum_hi_s;
      logic [DATA_WIDTH:0]   diff_s;
      logic                  ge_s;

      counter_adder #(.WIDTH(DATA_WIDTH)) u_step_adder (
         .a    (count_r),
         .b    (STEP_C),
         .cin  (1'b0),
         .sum  (sum_lo_s),
         .cout (sum_hi_s)
      );

      // (out+STEP) + ~TO + 1 = (out+STEP) - TO over DATA_WIDTH+1 bits;
      // carry-out means out+STEP >= TO.
      counter_adder #(.WIDTH(DATA_WIDTH + 32'd1)) u_cmp_adder (
         .a    ({sum_hi_s, sum_lo_s}),
         .b    (~{1'b0, TO_C}),
         .cin  (1'b1),
         .sum  (diff_s),
         .cout (ge_s)
      );

      // out+STEP > TO is the same test as (TO - out) < STEP, and also
      // catches out > TO.
      always_comb begin
         wrap_s = ge_s & (|diff_s);
         if (wrap_s) begin
            next_s = FROM_C;
         end else begin
            next_s = sum_lo_s;
         end
      end
   end else begin : g_arch_err
      $error("counter: ARCHITECTURE must be \"BEHAVIORAL\" or \"STRUCTURAL\"");
   end

   // Count register: reset beats enable, otherwise step or hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= FROM_C;
      end else if (en) begin
         count_r <= next_s;
      end else begin
         count_r <= count_r;
      end
   end

   assign out = count_r;

`ifdef COUNTER_WRAP_FLAG_EN
   logic wrap_r;

   // Wrap flag: marks a reload caused by the wrap rule, never by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrap_r <= 1'b0;
      end else begin
         wrap_r <= en & wrap_s;
      end
   end

   assign wrap = wrap_r;
`endif

endmodule

// File: tb/tb_counter.sv
// tb_counter -- scoreboard bench for counter. Three parameter groups
// (defaults, 10..20 step 3, 5..5), each built as BEHAVIORAL and STRUCTURAL
// and driven with the same stimulus; both copies are compared every cycle
// against a reference model of the counting rule.
module tb_counter;

   logic clk = 1'b0;
   always #1 clk = ~clk;

   logic       rst_g [3];
   logic       en_g  [3];
   logic [7:0] dout_beh [3];
   logic [7:0] dout_str [3];
   logic       dwrap_beh [3];
   logic       dwrap_str [3];

   typedef struct {
      int         grp;
      logic [7:0] val;
      bit         wrp;
      string      tag;
   } exp_t;

   exp_t        exp_q [$];
   int unsigned m_state [3];
   int          errors = 0;
   int          checks = 0;

   counter #(.ARCHITECTURE("BEHAVIORAL")) u_def_beh (
      .clk(clk), .rst(rst_g[0]), .en(en_g[0]), .out(dout_beh[0])
`ifdef COUNTER_WRAP_FLAG_EN
      , .wrap(dwrap_beh[0])
`endif
   );
   counter #(.ARCHITECTURE("STRUCTURAL")) u_def_str (
      .clk(clk), .rst(rst_g[0]), .en(en_g[0]), .out(dout_str[0])
`ifdef COUNTER_WRAP_FLAG_EN
      , .wrap(dwrap_str[0])
`endif
   );
   counter #(.ARCHITECTURE("BEHAVIORAL"), .COUNT_FROM(10), .COUNT_TO(20), .STEP(3)) u_r3_beh (
      .clk(clk), .rst(rst_g[1]), .en(en_g[1]), .out(dout_beh[1])
`ifdef COUNTER_WRAP_FLAG_EN
      , .wrap(dwrap_beh[1])
`endif
   );
   counter #(.ARCHITECTURE("STRUCTURAL"), .COUNT_FROM(10), .COUNT_TO(20), .STEP(3)) u_r3_str (
      .clk(clk), .rst(rst_g[1]), .en(en_g[1]), .out(dout_str[1])
`ifdef COUNTER_WRAP_FLAG_EN
      , .wrap(dwrap_str[1])
`endif
   );
   counter #(.ARCHITECTURE("BEHAVIORAL"), .COUNT_FROM(5), .COUNT_TO(5)) u_dg_beh (
      .clk(clk), .rst(rst_g[2]), .en(en_g[2]), .out(dout_beh[2])
`ifdef COUNTER_WRAP_FLAG_EN
      , .wrap(dwrap_beh[2])
`endif
   );
   counter #(.ARCHITECTURE("STRUCTURAL"), .COUNT_FROM(5), .COUNT_TO(5)) u_dg_str (
      .clk(clk), .rst(rst_g[2]), .en(en_g[2]), .out(dout_str[2])
`ifdef COUNTER_WRAP_FLAG_EN
      , .wrap(dwrap_str[2])
`endif
   );

`ifndef COUNTER_WRAP_FLAG_EN
   initial begin
      for (int i = 0; i < 3; i++) begin
         dwrap_beh[i] = 1'b0;
         dwrap_str[i] = 1'b0;
      end
   end
`endif

   function automatic int unsigned p_from(input int g);
      case (g)
         1:       return 10;
         2:       return 5;
         default: return 0;
      endcase
   endfunction

   function automatic int unsigned p_to(input int g);
      case (g)
         1:       return 20;
         2:       return 5;
         default: return 255;
      endcase
   endfunction

   function automatic int unsigned p_step(input int g);
      case (g)
         1:       return 3;
         default: return 1;
      endcase
   endfunction

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Pop the oldest expectation and compare both architectures against it.
   task automatic compare_out();
      exp_t x;
      if (exp_q.size() == 0) begin
         check_value("queue_empty", 32'd1, 32'd0);
      end else begin
         x = exp_q.pop_front();
         check_value($sformatf("g%0d_%s_beh", x.grp, x.tag), {24'd0, dout_beh[x.grp]}, {24'd0, x.val});
         check_value($sformatf("g%0d_%s_str", x.grp, x.tag), {24'd0, dout_str[x.grp]}, {24'd0, x.val});
`ifdef COUNTER_WRAP_FLAG_EN
         check_value($sformatf("g%0d_%s_wrap_beh", x.grp, x.tag), {31'd0, dwrap_beh[x.grp]}, {31'd0, x.wrp});
         check_value($sformatf("g%0d_%s_wrap_str", x.grp, x.tag), {31'd0, dwrap_str[x.grp]}, {31'd0, x.wrp});
`endif
      end
   endtask

   // Drive one cycle of group g, predict the result, and check it after the edge.
   task automatic step(input int g, input bit r, input bit e, input string tag);
      exp_t        x;
      int unsigned cur;
      int unsigned nxt;
      bit          w;
      cur = m_state[g];
      w   = 1'b0;
      if (r) begin
         nxt = p_from(g);
      end else if (e) begin
         if ((cur > p_to(g)) || ((p_to(g) - cur) < p_step(g))) begin
            nxt = p_from(g);
            w   = 1'b1;
         end else begin
            nxt = cur + p_step(g);
         end
      end else begin
         nxt = cur;
      end
      m_state[g] = nxt;
      rst_g[g]   = r;
      en_g[g]    = e;
      x.grp = g;
      x.val = nxt[7:0];
      x.wrp = w;
      x.tag = tag;
      exp_q.push_back(x);
      @(posedge clk);
      @(negedge clk);
      compare_out();
   endtask

   // Park a group in hold so other groups' edges leave it untouched.
   task automatic idle(input int g);
      rst_g[g] = 1'b0;
      en_g[g]  = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst_g[i]   = 1'b1;
         en_g[i]    = 1'b0;
         m_state[i] = 0;
      end
      @(negedge clk);

      // Defaults: reset, free count, hold at 254, wrap, reset with en at 42.
      step(0, 1'b1, 1'b0, "rst");
      step(0, 1'b1, 1'b0, "rst");
      for (int i = 0; i < 100; i++) step(0, 1'b0, 1'b1, "up");
      for (int i = 0; (i < 300) && (m_state[0] != 254); i++) step(0, 1'b0, 1'b1, "to254");
      repeat (3) step(0, 1'b0, 1'b0, "hold");
      repeat (3) step(0, 1'b0, 1'b1, "wrap");
      for (int i = 0; (i < 300) && (m_state[0] != 42); i++) step(0, 1'b0, 1'b1, "to42");
      step(0, 1'b1, 1'b1, "rst_en");
      repeat (2) step(0, 1'b0, 1'b1, "after_rst");
      idle(0);

      // 10..20 step 3: wraps from 19 without reaching 20; mid-count reset.
      step(1, 1'b1, 1'b0, "rst");
      repeat (8) step(1, 1'b0, 1'b1, "step3");
      step(1, 1'b1, 1'b0, "midrst");
      repeat (3) step(1, 1'b0, 1'b1, "step3b");
      idle(1);

      // Degenerate range 5..5: constant output.
      step(2, 1'b1, 1'b0, "rst");
      repeat (10) step(2, 1'b0, 1'b1, "const");
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
